// File: rtl/shared_mem_pkg.sv
// ============================================================================
// Module : shared_mem_pkg
// Desc   : Shared types and helpers for the shared instruction-memory return path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package shared_mem_pkg;

    localparam int N_REQ_DEFAULT = 8;

    typedef logic [$clog2(N_REQ_DEFAULT)-1:0] req_idx_t;

    // OR of the indices of all set bits: exact for one-hot, zero for all-zero.
    function automatic req_idx_t onehot_to_idx(input logic [N_REQ_DEFAULT-1:0] i_onehot);
        req_idx_t w_idx;
        w_idx = '0;
        for (int i = 0; i < N_REQ_DEFAULT; i++) begin
            if (i_onehot[i]) begin
                w_idx = w_idx | req_idx_t'(i);
            end
        end
        return w_idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/resp_tag_fifo.sv
// ============================================================================
// Module : resp_tag_fifo
// Desc   : Synchronous FIFO of requester tags; count-based full/empty detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module resp_tag_fifo
    import shared_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  req_idx_t                   i_wr_data,
    input  logic                       i_pop,
    output req_idx_t                   o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    req_idx_t          r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    // Storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = (r_count == c_DEPTH);

endmodule

`default_nettype wire

// File: rtl/shared_mem_response_router.sv
// ============================================================================
// Module : shared_mem_response_router
// Desc   : Steers in-order memory responses back to the granted requester.
//          Optional checker enabled by defining SHARED_MEM_ROUTER_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shared_mem_response_router
    import shared_mem_pkg::*;
#(
    parameter int N_REQ  = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           gnt,
    input  logic                       issue,
    input  logic                       rsp_vld,
    input  logic [DATA_W-1:0]          rsp_data,
    output logic [N_REQ-1:0]           out_vld,
    output logic [DATA_W-1:0]          out_data,
    output logic                       stall,
    output logic [$clog2(DEPTH):0]     outstanding
`ifdef SHARED_MEM_ROUTER_CHECK_EN
    ,
    output logic                       err_sticky
`endif
);

    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    req_idx_t                w_wr_tag;
    req_idx_t                w_rd_tag;
    logic [$clog2(DEPTH):0]  w_count;
    logic [N_REQ-1:0]        r_out_vld;
    logic [DATA_W-1:0]       r_out_data;

    assign w_empty  = (w_count == '0);
    assign w_pop    = rsp_vld && !w_empty;
    // A pop in the same cycle frees the slot being written when full.
    assign w_push   = issue && (gnt != '0) && (!w_full || rsp_vld);
    assign w_wr_tag = onehot_to_idx(gnt);

    resp_tag_fifo #(
        .DEPTH     (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_wr_data (w_wr_tag),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_tag),
        .o_count   (w_count),
        .o_full    (w_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld  <= '0;
            r_out_data <= '0;
        end else if (w_pop) begin
            r_out_vld  <= N_REQ'(1) << w_rd_tag;
            r_out_data <= rsp_data;
        end else begin
            r_out_vld  <= '0;
        end
    end

    assign out_vld     = r_out_vld;
    assign out_data    = r_out_data;
    assign outstanding = w_count;
    assign stall       = w_full;

`ifdef SHARED_MEM_ROUTER_CHECK_EN
    logic w_gnt_onehot;
    logic w_bad_gnt;
    logic w_bad_full;
    logic w_bad_empty;
    logic r_err_sticky;

    assign w_gnt_onehot = (gnt != '0) && ((gnt & (gnt - N_REQ'(1))) == '0);
    assign w_bad_gnt    = issue && !w_gnt_onehot;
    assign w_bad_full   = issue && w_full && !w_pop;
    assign w_bad_empty  = rsp_vld && w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (w_bad_gnt || w_bad_full || w_bad_empty) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign err_sticky = r_err_sticky;

`ifndef SYNTHESIS
    a_gnt_onehot:  assert property (@(posedge clk) disable iff (rst) !w_bad_gnt);
    a_issue_full:  assert property (@(posedge clk) disable iff (rst) !w_bad_full);
    a_rsp_empty:   assert property (@(posedge clk) disable iff (rst) !w_bad_empty);
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_shared_mem_response_router.sv
// ============================================================================
// Module : tb_shared_mem_response_router
// Desc   : Self-checking bench: directed vector table, reset sequence, random vs queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shared_mem_response_router;

    localparam int N_REQ  = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic [N_REQ-1:0]  gnt;
    logic              issue;
    logic              rsp_vld;
    logic [DATA_W-1:0] rsp_data;
    logic [N_REQ-1:0]  out_vld;
    logic [DATA_W-1:0] out_data;
    logic              stall;
    logic [$clog2(DEPTH):0] outstanding;
`ifdef SHARED_MEM_ROUTER_CHECK_EN
    logic              err_sticky;
`endif

    shared_mem_response_router #(
        .N_REQ       (N_REQ),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gnt         (gnt),
        .issue       (issue),
        .rsp_vld     (rsp_vld),
        .rsp_data    (rsp_data),
        .out_vld     (out_vld),
        .out_data    (out_data),
        .stall       (stall),
        .outstanding (outstanding)
`ifdef SHARED_MEM_ROUTER_CHECK_EN
        ,
        .err_sticky  (err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic              issue;
        logic [N_REQ-1:0]  gnt;
        logic              rsp_vld;
        logic [DATA_W-1:0] rsp_data;
        logic [N_REQ-1:0]  exp_vld;
        logic [DATA_W-1:0] exp_data;
        int                exp_out;
        logic              exp_stall;
    } vec_t;

    vec_t vecs[18];

    // Reference model: plain queue of issuer indices in issue order.
    int                m_q[$];
    logic [N_REQ-1:0]  m_vld;
    logic [DATA_W-1:0] m_data;

    function automatic int idx_of(input logic [N_REQ-1:0] g);
        for (int i = 0; i < N_REQ; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic model_step();
        bit do_pop;
        bit do_push;
        do_pop  = rsp_vld && (m_q.size() != 0);
        do_push = issue && (gnt != 0) && ((m_q.size() < DEPTH) || rsp_vld);
        if (do_pop) begin
            m_vld  = '0;
            m_vld[m_q.pop_front()] = 1'b1;
            m_data = rsp_data;
        end else begin
            m_vld = '0;
        end
        if (do_push) m_q.push_back(idx_of(gnt));
    endtask

    task automatic model_cycle(input string name);
        @(posedge clk);
        #1;
        model_step();
        check({name, ".out_vld"}, 64'(out_vld), 64'(m_vld));
        check({name, ".out_data"}, 64'(out_data), 64'(m_data));
        check({name, ".outstanding"}, 64'(outstanding), 64'(m_q.size()));
        check({name, ".stall"}, 64'(stall), 64'(m_q.size() == DEPTH));
    endtask

    task automatic drive(input logic iss, input logic [N_REQ-1:0] g,
                         input logic rv, input logic [DATA_W-1:0] rd);
        issue = iss; gnt = g; rsp_vld = rv; rsp_data = rd;
    endtask

    initial begin
        //                 issue gnt    rsp  data            exp_vld exp_data       out stall
        vecs[0]  = '{1'b1, 8'h04, 1'b0, 32'h0,           8'h00, 32'h0,           1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 32'h0,           8'h00, 32'h0,           1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 32'hDEAD_0001,   8'h04, 32'hDEAD_0001,   0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 32'h0,           8'h00, 32'hDEAD_0001,   0, 1'b0};
        vecs[4]  = '{1'b1, 8'h01, 1'b0, 32'h0,           8'h00, 32'hDEAD_0001,   1, 1'b0};
        vecs[5]  = '{1'b1, 8'h80, 1'b0, 32'h0,           8'h00, 32'hDEAD_0001,   2, 1'b0};
        vecs[6]  = '{1'b1, 8'h10, 1'b0, 32'h0,           8'h00, 32'hDEAD_0001,   3, 1'b0};
        vecs[7]  = '{1'b1, 8'h02, 1'b0, 32'h0,           8'h00, 32'hDEAD_0001,   4, 1'b1};
        vecs[8]  = '{1'b1, 8'h20, 1'b0, 32'h0,           8'h00, 32'hDEAD_0001,   4, 1'b1};
        vecs[9]  = '{1'b1, 8'h08, 1'b1, 32'hAAAA_0001,   8'h01, 32'hAAAA_0001,   4, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 32'hBBBB_0002,   8'h80, 32'hBBBB_0002,   3, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 32'hCCCC_0003,   8'h10, 32'hCCCC_0003,   2, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 32'hDDDD_0004,   8'h02, 32'hDDDD_0004,   1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 32'hEEEE_0005,   8'h08, 32'hEEEE_0005,   0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 32'h0000_1234,   8'h00, 32'hEEEE_0005,   0, 1'b0};
        vecs[15] = '{1'b1, 8'h00, 1'b0, 32'h0,           8'h00, 32'hEEEE_0005,   0, 1'b0};
        vecs[16] = '{1'b1, 8'h40, 1'b1, 32'h5555_5555,   8'h00, 32'hEEEE_0005,   1, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 32'h6666_6666,   8'h40, 32'h6666_6666,   0, 1'b0};

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0);
        #1;
        check("reset.out_vld", 64'(out_vld), 64'h0);
        check("reset.out_data", 64'(out_data), 64'h0);
        check("reset.outstanding", 64'(outstanding), 64'h0);
        check("reset.stall", 64'(stall), 64'h0);
`ifdef SHARED_MEM_ROUTER_CHECK_EN
        check("reset.err_sticky", 64'(err_sticky), 64'h0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].issue, vecs[i].gnt, vecs[i].rsp_vld, vecs[i].rsp_data);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.out_vld", i), 64'(out_vld), 64'(vecs[i].exp_vld));
            check($sformatf("vec%0d.out_data", i), 64'(out_data), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d.outstanding", i), 64'(outstanding), 64'(vecs[i].exp_out));
            check($sformatf("vec%0d.stall", i), 64'(stall), 64'(vecs[i].exp_stall));
        end
`ifdef SHARED_MEM_ROUTER_CHECK_EN
        check("table.err_sticky", 64'(err_sticky), 64'h1);
`endif

        // Asynchronous reset with three tags outstanding and a live out_vld.
        drive(1'b1, 8'h01, 1'b0, '0); @(posedge clk); #1;
        drive(1'b1, 8'h02, 1'b0, '0); @(posedge clk); #1;
        drive(1'b1, 8'h04, 1'b0, '0); @(posedge clk); #1;
        drive(1'b1, 8'h08, 1'b0, '0); @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b1, 32'h7777_0007); @(posedge clk); #1;
        check("pre_rst.out_vld", 64'(out_vld), 64'h01);
        check("pre_rst.outstanding", 64'(outstanding), 64'd3);
        drive(1'b0, 8'h00, 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        check("async_rst.out_vld", 64'(out_vld), 64'h0);
        check("async_rst.out_data", 64'(out_data), 64'h0);
        check("async_rst.outstanding", 64'(outstanding), 64'h0);
        check("async_rst.stall", 64'(stall), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_vld  = '0;
        m_data = '0;
        drive(1'b0, 8'h00, 1'b1, 32'h9999_0009);
        model_cycle("post_rst_drop");

        // Pointer wrap: ten back-to-back push/pop pairs.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, N_REQ'(1) << ((i * 3) % N_REQ), 1'b0, '0);
            model_cycle("wrap_push");
            drive(1'b0, 8'h00, 1'b1, 32'hC0DE_0000 + DATA_W'(i));
            model_cycle("wrap_pop");
        end

        // Random traffic, including stall violations and zero grants.
        for (int i = 0; i < 400; i++) begin
            logic [N_REQ-1:0] g;
            g = ($urandom_range(0, 7) == 0) ? '0 : (N_REQ'(1) << $urandom_range(0, N_REQ - 1));
            drive(1'($urandom_range(0, 1)), g, 1'($urandom_range(0, 1)), DATA_W'($urandom));
            model_cycle("random");
        end

        // Drain so every remaining tag is delivered.
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1'b0, 8'h00, 1'b1, DATA_W'($urandom));
            model_cycle("drain");
        end
        drive(1'b0, 8'h00, 1'b0, '0);
        model_cycle("idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shared_mem_response_router.md
Name: shared_mem_response_router

Overview:
- Return-path companion to the 8-way round-robin request arbiter in front of a shared in-order instruction memory.
- Records which requester was granted for every request the memory accepts.
- When the memory returns data, steers each in-order response to the requester that issued it.
- Applies backpressure to the arbiter when the outstanding-tag buffer is full.

Parameters:
- N_REQ, 8, number of requesters; must match the arbiter width.
- DATA_W, 32, response data width.
- DEPTH, 4, maximum outstanding requests; power of two, at least 2.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- gnt  input  N_REQ  one-hot grant from the arbiter for the current cycle.
- issue  input  1  memory accepted a request this cycle, on behalf of the requester in gnt.
- rsp_vld  input  1  memory returns one response this cycle, in issue order.
- rsp_data  input  DATA_W  response payload.
- out_vld  output  N_REQ  per-requester response valid, one-hot or zero.
- out_data  output  DATA_W  response payload, shared by all requesters.
- stall  output  1  tag buffer is full; the arbiter must not issue.
- outstanding  output  $clog2(DEPTH)+1  number of tags currently held.

Behaviour:
- Reset (async assert, sync deassert at the clock edge): out_vld=0, out_data=0, outstanding=0, stall=0, read/write pointers=0.
- Push condition: issue && (gnt != 0) && (!full || rsp_vld).
  - The encoded index of gnt, width $clog2(N_REQ), is written at the write pointer.
  - The write pointer increments mod DEPTH.
- Issue with gnt == 0: ignored; no push.
- Issue while full and no pop in the same cycle: ignored, and the request is lost. The arbiter owns honouring stall.
- Pop condition: rsp_vld && (outstanding != 0). The tag at the read pointer is read and the read pointer increments mod DEPTH.
- Response while empty: dropped. out_vld stays 0 and outstanding stays 0.
- Simultaneous push and pop: outstanding is unchanged.
  - When full, both proceed and stall stays 1.
  - When empty, the response is dropped and the push proceeds, so memory latency is at least 1 cycle.
- Output latency is 1 cycle, registered.
  - Cycle after a pop: out_vld[tag]=1, all other out_vld bits 0, out_data=rsp_data.
  - With no pop, out_vld=0 and out_data holds its last value.
- stall = (outstanding == DEPTH). It is combinational from registered state, so it has no path from inputs.
- Pointers wrap mod DEPTH. Full and empty are distinguished by the count, not by pointer equality alone.
- Reset mid-operation discards all outstanding tags. Responses arriving after reset are treated as empty-case responses and dropped.

Optional Feature:
- Macro: SHARED_MEM_ROUTER_CHECK_EN.
- When defined, adds output err_sticky (1 bit, reset 0). It is set and held until reset on any of:
  - issue with gnt not one-hot, including zero;
  - issue while full with no pop;
  - rsp_vld while empty.
- When defined, also adds simulation-only assertions for the same three conditions.
- When undefined, the port and the logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package shared_mem_pkg holds:
  - N_REQ_DEFAULT = 8;
  - typedef req_idx_t as logic [$clog2(N_REQ_DEFAULT)-1:0];
  - function onehot_to_idx, used for the gnt encode.
- One sub-module, resp_tag_fifo: synchronous FIFO of req_idx_t, depth DEPTH, with push, pop, rd_data, count and full.
- The top level holds the push/pop qualification, the output register and the optional checker.

Test Plan:
- Reset, then issue gnt=8'h04 once, then rsp_vld with rsp_data=32'hDEAD_0001 two cycles later -> next cycle out_vld=8'h04 and out_data=32'hDEAD_0001; outstanding goes 0→1→0.
- Issue gnt=01, 80, 10, 02 in consecutive cycles (DEPTH=4) -> stall=1 and outstanding=4. Then 4 responses A,B,C,D -> out_vld sequence 01, 80, 10, 02 with matching data.
- While full, drive issue with gnt=08 and rsp_vld in the same cycle -> both proceed and outstanding stays 4. The remaining responses end with out_vld=08.
- rsp_vld with rsp_data=32'h1234 while empty -> out_vld stays 0 and outstanding stays 0; with SHARED_MEM_ROUTER_CHECK_EN, err_sticky=1.
- Run 3 outstanding, assert rst mid-cycle -> out_vld=0, outstanding=0 and stall=0 immediately (async). A following response is dropped.
- Run 10 push/pop pairs to exercise pointer wrap -> every response is delivered to its issuer in order, with no spurious out_vld.
